// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage core.
// Merges load-use, branch, memory-wait and mul/div hazards; adds watchdog and counters.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             ex_muldiv_start,
    input  logic             muldiv_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             bubble_mem,
    output logic             bubble_wb,
    output logic             error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        ERROR   = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [WD_W-1:0] wd_q;

    logic mw;
    logic hz_rs1;
    logic hz_rs2;
    logic load_use;
    logic md_stall;
    logic br_flush;
    logic wd_fire;

    // Raw hazard terms shared by the sequencer and the watchdog.
    always_comb begin
        mw       = mem_req & ~mem_ready;
        hz_rs1   = id_uses_rs1 & (id_rs1_addr == ex_rd_addr);
        hz_rs2   = id_uses_rs2 & (id_rs2_addr == ex_rd_addr);
        load_use = ex_is_load & (ex_rd_addr != 5'd0) & (hz_rs1 | hz_rs2);
        wd_fire  = (MEM_TIMEOUT != 0) && mw
                   && (wd_q == WD_W'(MEM_TIMEOUT - 1));
    end

    // Next state plus Mealy stall/flush outputs, highest priority first.
    always_comb begin
        state_d    = state_q;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        stall_mem  = 1'b0;
        flush_id   = 1'b0;
        flush_ex   = 1'b0;
        bubble_mem = 1'b0;
        bubble_wb  = 1'b0;
        error      = 1'b0;
        md_stall   = 1'b0;
        br_flush   = 1'b0;

        unique case (state_q)
            RUN: begin
                md_stall = ex_muldiv_start & ~muldiv_done & ~mw;
                if (md_stall) begin
                    state_d = MD_WAIT;
                end
            end
            MD_WAIT: begin
                md_stall = ~muldiv_done;
                if (muldiv_done & ~mw) begin
                    state_d = RUN;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (state_q == ERROR) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            error     = 1'b1;
        end else begin
            if (mw) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
                bubble_wb = 1'b1;
            end
            if (md_stall) begin
                stall_if   = 1'b1;
                stall_id   = 1'b1;
                stall_ex   = 1'b1;
                bubble_mem = 1'b1;
            end
            // The ID instruction is on the wrong path, so a branch
            // wins over any load-use bubble.
            br_flush = ex_branch_taken & ~stall_ex;
            if (br_flush) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end
            if ((state_q == RUN) & ~mw & ~md_stall & ~br_flush & load_use) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
            if (wd_fire) begin
                state_d = ERROR;
            end
        end
    end

    // State register; ERROR is only left through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Counts consecutive memory-wait cycles for the watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if ((state_q == ERROR) || !mw) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    // Saturating stall and flush performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_if && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_id && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and random checks of pipeline_ctrl
// against a rule-level hazard model.
module tb_pipeline_ctrl;

    localparam int MT   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic          id_uses_rs1, id_uses_rs2;
    logic          ex_is_load, ex_branch_taken;
    logic          ex_muldiv_start, muldiv_done;
    logic          mem_req, mem_ready;
    logic          stall_if, stall_id, stall_ex, stall_mem;
    logic          flush_id, flush_ex, bubble_mem, bubble_wb, error;
    logic [CW-1:0] stall_cycles, flush_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic sif, sid, sex, smem, fid, fex, bmem, bwb, err;
    } exp_t;

    bit   m_md  = 0;
    bit   m_err = 0;
    int   m_wd  = 0;
    int   m_sc  = 0;
    int   m_fc  = 0;
    exp_t mu;
    exp_t me;

    pipeline_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken),
        .ex_muldiv_start(ex_muldiv_start), .muldiv_done(muldiv_done),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_id(stall_id),
        .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .bubble_mem(bubble_mem), .bubble_wb(bubble_wb),
        .error(error), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expected controls from the hazard rules and the model's mode.
    function automatic exp_t model_out();
        exp_t e;
        bit mw, busy, br, lu, hit;
        e = '0;
        if (m_err) begin
            e.sif = 1; e.sid = 1; e.sex = 1; e.smem = 1; e.err = 1;
            return e;
        end
        mw   = mem_req && !mem_ready;
        busy = !muldiv_done && (m_md || (ex_muldiv_start && !mw));
        br   = ex_branch_taken && !(mw || busy);
        hit  = (id_uses_rs1 && id_rs1_addr == ex_rd_addr)
            || (id_uses_rs2 && id_rs2_addr == ex_rd_addr);
        lu   = !m_md && !mw && !busy && !br
            && ex_is_load && ex_rd_addr != 0 && hit;
        e.sif  = mw || busy || lu;
        e.sid  = mw || busy || lu;
        e.sex  = mw || busy;
        e.smem = mw;
        e.fid  = br;
        e.fex  = br || lu;
        e.bmem = busy;
        e.bwb  = mw;
        return e;
    endfunction

    // Model advance on each clock edge, cleared by reset.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_md = 0; m_err = 0; m_wd = 0; m_sc = 0; m_fc = 0;
        end else begin
            mu = model_out();
            if (!m_err) begin
                if (mem_req && !mem_ready) begin
                    m_wd = m_wd + 1;
                end else begin
                    m_wd = 0;
                    if (m_md && muldiv_done) m_md = 0;
                    else if (!m_md && ex_muldiv_start && !muldiv_done) m_md = 1;
                end
                if (MT > 0 && m_wd >= MT) m_err = 1;
            end
            if (mu.sif && m_sc < CMAX) m_sc = m_sc + 1;
            if (mu.fid && m_fc < CMAX) m_fc = m_fc + 1;
        end
    end

    // Every-cycle comparison of DUT against the model.
    initial forever begin
        @(negedge clk);
        me = model_out();
        chk("model_ctrl",
            int'({stall_if, stall_id, stall_ex, stall_mem, flush_id,
                  flush_ex, bubble_mem, bubble_wb, error}), int'(me));
        chk("model_stall_cycles", int'(stall_cycles), m_sc);
        chk("model_flush_count", int'(flush_count), m_fc);
    end

    task automatic clr();
        id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_is_load = 0;
        ex_branch_taken = 0; ex_muldiv_start = 0; muldiv_done = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 0;
        clr();
        cyc();
        rst_n = 1;
    endtask

    task automatic lu_hazard();
        ex_is_load = 1; ex_rd_addr = 5; id_rs2_addr = 5; id_uses_rs2 = 1;
    endtask

    initial begin
        rst_n = 0;
        clr();
        at_neg();
        chk("rst_ctrl", int'({stall_if, stall_id, stall_ex, stall_mem, flush_id,
            flush_ex, bubble_mem, bubble_wb, error}), 0);
        chk("rst_sc", int'(stall_cycles), 0);
        chk("rst_fc", int'(flush_count), 0);
        cyc();
        rst_n = 1;

        id_rs1_addr = 7; id_uses_rs1 = 1;
        lu_hazard();
        at_neg();
        chk("lu_stall", int'({stall_if, stall_id, flush_ex}), 7);
        chk("lu_no_ex_stall", int'({stall_ex, flush_id}), 0);
        cyc();
        ex_is_load = 0;
        at_neg();
        chk("lu_release", int'(stall_if), 0);
        chk("lu_sc", int'(stall_cycles), 1);
        cyc();
        lu_hazard();
        ex_rd_addr = 0; id_rs2_addr = 0;
        at_neg();
        chk("lu_x0", int'({stall_if, flush_ex}), 0);
        cyc();
        lu_hazard();
        id_uses_rs2 = 0;
        at_neg();
        chk("lu_nouse", int'({stall_if, flush_ex}), 0);

        cyc();
        lu_hazard();
        ex_branch_taken = 1;
        at_neg();
        chk("br_flush", int'({flush_id, flush_ex}), 3);
        chk("br_no_stall", int'(stall_if), 0);
        cyc();
        clr();
        at_neg();
        chk("br_fc", int'(flush_count), 1);

        do_reset();
        ex_muldiv_start = 1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("md_stall", int'({stall_if, stall_id, stall_ex, bubble_mem}), 15);
            cyc();
        end
        muldiv_done = 1;
        at_neg();
        chk("md_release", int'({stall_if, stall_id, stall_ex, bubble_mem}), 0);
        cyc();
        clr();
        lu_hazard();
        at_neg();
        chk("md_sc", int'(stall_cycles), 3);
        chk("md_back_run", int'({stall_if, stall_ex}), 2);

        do_reset();
        ex_muldiv_start = 1;
        at_neg();
        cyc();
        muldiv_done = 1; mem_req = 1;
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("mwmd_stall", int'({stall_if, stall_id, stall_ex, stall_mem}), 15);
            cyc();
        end
        mem_ready = 1;
        at_neg();
        chk("mwmd_release", int'({stall_if, stall_id, stall_ex, stall_mem}), 0);
        cyc();
        clr();
        lu_hazard();
        at_neg();
        chk("mwmd_back_run", int'(stall_if), 1);

        do_reset();
        mem_req = 1;
        repeat (3) cyc();
        mem_ready = 1;
        at_neg();
        cyc();
        mem_ready = 0;
        at_neg();
        chk("wd_near_miss", int'(error), 0);

        do_reset();
        mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("wd_pre", int'(error), 0);
            cyc();
        end
        at_neg();
        chk("wd_fire", int'(error), 1);
        cyc();
        mem_ready = 1;
        at_neg();
        chk("wd_hold", int'(error), 1);
        chk("wd_err_ctrl", int'({stall_if, stall_id, stall_ex, stall_mem,
            flush_id, flush_ex, bubble_mem, bubble_wb}), 8'hF0);
        #2;
        rst_n = 0;
        clr();
        #1;
        chk("wd_async_clr", int'({error, stall_if, stall_mem}), 0);
        cyc();
        rst_n = 1;

        do_reset();
        ex_muldiv_start = 1;
        repeat (20) cyc();
        clr();
        at_neg();
        chk("sat_sc", int'(stall_cycles), 15);

        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 49) == 0) rst_n = 0;
            id_rs1_addr     = 5'($urandom_range(0, 3));
            id_rs2_addr     = 5'($urandom_range(0, 3));
            ex_rd_addr      = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_is_load      = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 6) == 0);
            ex_muldiv_start = ($urandom_range(0, 4) == 0);
            muldiv_done     = ($urandom_range(0, 2) == 0);
            mem_req         = ($urandom_range(0, 3) == 0);
            mem_ready       = 1'($urandom_range(0, 1));
        end
        cyc();
        clr();
        at_neg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
